// File: rtl/spi_aes_pkg.sv
// Shared definitions for the AES-link SPI subordinate: header mode codes,
// payload lengths, FSM state encoding and a saturating counter helper.
package spi_aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    localparam int unsigned LEN_128  = 128;
    localparam int unsigned LEN_192  = 192;
    localparam int unsigned LEN_256  = 256;
    localparam int unsigned HDR_BITS = 2;

    // Bit counters are 9 bits wide and stick at their maximum.
    localparam int unsigned CNT_W = 9;

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Payload length for a valid header; MODE_BAD never reaches here.
    function automatic logic [CNT_W-1:0] mode_len(input logic [1:0] m);
        case (m)
            MODE_192: return CNT_W'(LEN_192);
            MODE_256: return CNT_W'(LEN_256);
            default:  return CNT_W'(LEN_128);
        endcase
    endfunction

endpackage

// File: rtl/spi_sub_aes_if.sv
// SPI pin bundle between the AES-link main and subordinate.
interface spi_sub_aes_if;

    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for an asynchronous pin followed by one edge-detect
// register. rise/fall are single-clk events aligned with the last sync stage.
// The chain resets to 0 so a low pin never produces a spurious edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;

    // Shift the pin through the synchronizer and remember the previous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            q_d   <= 1'b0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            q_d <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~q_d;
    assign fall = ~chain[SYNC_STAGES-1] & q_d;

endmodule

// File: rtl/spi_sub_aes.sv
// SPI subordinate endpoint for the AES link. Oversamples sclk/cs_n/mosi on
// the system clock, receives a 2-bit key-size header plus payload, and
// returns a 128-bit result on miso during the first 128 bit periods.
module spi_sub_aes
    import spi_aes_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESULT_W    = 128,
    parameter int unsigned MAX_PAYLOAD = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_sub_aes_if.slave           spi,
    input  logic [RESULT_W-1:0]    tx_data,
    output logic [1:0]             rx_mode,
    output logic [MAX_PAYLOAD-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int unsigned      TX_IDX_W   = $clog2(RESULT_W);
    localparam logic [CNT_W-1:0] RESULT_CNT = CNT_W'(RESULT_W);
    localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);

    logic sclk_rise_raw, sclk_fall_raw, sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    state_t                 state, state_n;
    logic                   cs_high, cs_high_n;
    logic [CNT_W-1:0]       fall_cnt, fall_cnt_n;
    logic [CNT_W-1:0]       pay_cnt, pay_cnt_n;
    logic [CNT_W-1:0]       len, len_n;
    logic [1:0]             hdr, hdr_n;
    logic [MAX_PAYLOAD-1:0] payload_sr, payload_sr_n;
    logic [RESULT_W-1:0]    tx_shadow, tx_shadow_n;
    logic                   miso_q, miso_n;
    logic [1:0]             rx_mode_n;
    logic [MAX_PAYLOAD-1:0] rx_data_n;
    logic                   rx_valid_n, frame_err_n, busy_n;
    logic [TX_IDX_W-1:0]    tx_idx;
    logic                   in_frame;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi.sclk),
        .rise (sclk_rise_raw),
        .fall (sclk_fall_raw)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi.cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi only needs a synchronized level, aligned with the sclk edge events.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain[0] <= spi.mosi;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                mosi_chain[i] <= mosi_chain[i-1];
            end
        end
    end

    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    // cs_high tracks the previous synchronized cs_n level, so an sclk edge
    // arriving in the same clk as the cs_n rise is still accepted.
    assign sclk_rise = sclk_rise_raw & ~cs_high;
    assign sclk_fall = sclk_fall_raw & ~cs_high;

    assign spi.miso = miso_q;

    // Register FSM state and all datapath/output state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_WAIT_IDLE;
            cs_high    <= 1'b0;
            fall_cnt   <= '0;
            pay_cnt    <= '0;
            len        <= '0;
            hdr        <= '0;
            payload_sr <= '0;
            tx_shadow  <= '0;
            miso_q     <= 1'b0;
            rx_mode    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cs_high    <= cs_high_n;
            fall_cnt   <= fall_cnt_n;
            pay_cnt    <= pay_cnt_n;
            len        <= len_n;
            hdr        <= hdr_n;
            payload_sr <= payload_sr_n;
            tx_shadow  <= tx_shadow_n;
            miso_q     <= miso_n;
            rx_mode    <= rx_mode_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            frame_err  <= frame_err_n;
            busy       <= busy_n;
        end
    end

    // Next-state and datapath decode; sclk falls are handled before a
    // coincident cs_n rise so a frame finishing on that clk still completes.
    always_comb begin
        state_n      = state;
        fall_cnt_n   = fall_cnt;
        pay_cnt_n    = pay_cnt;
        len_n        = len;
        hdr_n        = hdr;
        payload_sr_n = payload_sr;
        tx_shadow_n  = tx_shadow;
        miso_n       = miso_q;
        rx_mode_n    = rx_mode;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        frame_err_n  = 1'b0;
        busy_n       = busy;

        cs_high_n = cs_rise ? 1'b1 : (cs_fall ? 1'b0 : cs_high);
        tx_idx    = TX_IDX_W'(RESULT_W - 1) - fall_cnt[TX_IDX_W-1:0];
        in_frame  = state inside {S_HDR, S_PAYLOAD, S_DRAIN};

        if (cs_high) begin
            miso_n = 1'b0;
        end

        unique case (state)
            S_WAIT_IDLE: begin
                if (cs_rise || cs_high) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cs_fall) begin
                    tx_shadow_n  = tx_data;
                    miso_n       = tx_data[RESULT_W-1];
                    fall_cnt_n   = '0;
                    pay_cnt_n    = '0;
                    hdr_n        = '0;
                    payload_sr_n = '0;
                    busy_n       = 1'b1;
                    state_n      = S_HDR;
                end
            end
            S_HDR: begin
                if (sclk_fall) begin
                    hdr_n = {hdr[0], mosi_s};
                    if (fall_cnt == HDR_LAST) begin
                        if (hdr_n == MODE_BAD) begin
                            frame_err_n = 1'b1;
                            state_n     = S_DRAIN;
                        end else begin
                            len_n   = mode_len(hdr_n);
                            state_n = S_PAYLOAD;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (sclk_fall) begin
                    payload_sr_n = {payload_sr[MAX_PAYLOAD-2:0], mosi_s};
                    pay_cnt_n    = sat_inc(pay_cnt);
                    if (pay_cnt_n == len) begin
                        // payload_sr starts cleared, so it is already right-aligned
                        // and zero-extended for shorter modes.
                        rx_data_n  = payload_sr_n;
                        rx_mode_n  = hdr;
                        rx_valid_n = 1'b1;
                        state_n    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
            end
            default: begin
                state_n = S_WAIT_IDLE;
            end
        endcase

        if (in_frame) begin
            if (sclk_fall) begin
                fall_cnt_n = sat_inc(fall_cnt);
            end
            if (sclk_rise) begin
                miso_n = (fall_cnt < RESULT_CNT) ? tx_shadow[tx_idx] : 1'b0;
            end
            if (cs_rise) begin
                if (state_n != S_DRAIN) begin
                    frame_err_n = 1'b1;
                end
                state_n = S_IDLE;
                busy_n  = 1'b0;
                miso_n  = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_sub_aes.sv
// Directed bench for spi_sub_aes: a table of whole frames with hand-computed
// results, plus sequences for cs_n rising on the final fall and reset mid-frame.
module tb_spi_sub_aes;

    localparam int HALF = 5;

    typedef struct {
        logic [1:0]   hdr;
        logic [255:0] pay;
        int           nbits;
        logic [127:0] tx;
        int           tail;
        int           gap;
        bit           miso_chk;
        int           exp_valid;
        int           exp_err;
        logic [1:0]   exp_mode;
        logic [255:0] exp_data;
    } vec_t;

    localparam logic [127:0] P0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [255:0] P1 = {16{16'hA55A}};
    localparam logic [255:0] P2 = {64'd0, 192'h112233445566778899AABBCCDDEEFF000123456789ABCDEF};
    localparam logic [127:0] P3 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] T0 = 128'hDEADBEEF0BADF00D123456789ABCCAFE;
    localparam logic [127:0] T1 = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tx_data;
    logic [1:0]   rx_mode;
    logic [255:0] rx_data;
    logic         rx_valid, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int ecnt   = 0;

    vec_t vecs[8];

    spi_sub_aes_if spi ();

    spi_sub_aes #(.SYNC_STAGES(2), .RESULT_W(128), .MAX_PAYLOAD(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .tx_data   (tx_data),
        .rx_mode   (rx_mode),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)  vcnt++;
        if (frame_err) ecnt++;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] hdr, input logic [255:0] pay, input int nbits,
                                input logic [127:0] tx, input int tail, input int gap,
                                input bit miso_chk, input int ev, input int ee,
                                input logic [1:0] em, input logic [255:0] ed);
        vec_t v;
        v.hdr = hdr; v.pay = pay; v.nbits = nbits; v.tx = tx;
        v.tail = tail; v.gap = gap; v.miso_chk = miso_chk;
        v.exp_valid = ev; v.exp_err = ee; v.exp_mode = em; v.exp_data = ed;
        return v;
    endfunction

    // Drives one frame as the SPI main would; called at a negedge of clk.
    task automatic run_frame(input vec_t v, input int rst_at, input int tag);
        int           total, v0, e0;
        logic         b;
        logic [255:0] t;
        logic [127:0] cap;
        logic         late_nz;
        tx_data = v.tx;
        v0      = vcnt;
        e0      = ecnt;
        cap     = '0;
        late_nz = 1'b0;
        total   = 2 + v.nbits;
        spi.cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        tx_data = ~v.tx;
        for (int i = 0; i < total; i++) begin
            if (i == 0)      b = v.hdr[1];
            else if (i == 1) b = v.hdr[0];
            else begin
                t = v.pay >> (v.nbits - 1 - (i - 2));
                b = t[0];
            end
            spi.sclk = 1'b1;
            spi.mosi = b;
            repeat (HALF) @(negedge clk);
            if (i < 128) cap = {cap[126:0], spi.miso};
            else         late_nz = late_nz | spi.miso;
            spi.sclk = 1'b0;
            if (i == 4)
                chk($sformatf("v%0d early_err", tag), 256'(ecnt - e0), 256'(v.hdr == 2'b11));
            if (i == 10)
                chk($sformatf("v%0d busy_mid", tag), 256'(busy), 256'd1);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            if (i != total - 1) repeat (HALF) @(negedge clk);
        end
        repeat (v.tail) @(negedge clk);
        spi.cs_n = 1'b1;
        repeat (v.gap) @(negedge clk);
        chk($sformatf("v%0d valid_cnt", tag), 256'(vcnt - v0), 256'(v.exp_valid));
        chk($sformatf("v%0d err_cnt", tag), 256'(ecnt - e0), 256'(v.exp_err));
        chk($sformatf("v%0d rx_mode", tag), 256'(rx_mode), 256'(v.exp_mode));
        chk($sformatf("v%0d rx_data", tag), rx_data, v.exp_data);
        if (v.miso_chk) begin
            chk($sformatf("v%0d miso_result", tag), 256'(cap), 256'(v.tx));
            if (total > 128)
                chk($sformatf("v%0d miso_tail_zero", tag), 256'(late_nz), 256'd0);
        end
        if (v.gap > 4)
            chk($sformatf("v%0d busy_end", tag), 256'(busy), 256'd0);
    endtask

    initial begin
        vecs[0] = mk(2'b00, {128'd0, P0}, 128, T0, 6, 20, 1'b1, 1, 0, 2'b00, {128'd0, P0});
        vecs[1] = mk(2'b10, P1, 256, T1, 6, 20, 1'b1, 1, 0, 2'b10, P1);
        vecs[2] = mk(2'b01, P2, 192, T0, 6, 1, 1'b1, 1, 0, 2'b01, P2);
        vecs[3] = mk(2'b00, {128'd0, P3}, 128, T1, 6, 20, 1'b1, 1, 0, 2'b00, {128'd0, P3});
        vecs[4] = mk(2'b11, {128'd0, P0}, 130, T0, 6, 20, 1'b1, 0, 1, 2'b00, {128'd0, P3});
        vecs[5] = mk(2'b00, {128'd0, P0}, 100, T1, 6, 20, 1'b0, 0, 1, 2'b00, {128'd0, P3});
        vecs[6] = mk(2'b01, P2, 192, T1, 6, 20, 1'b1, 1, 0, 2'b01, P2);
        vecs[7] = mk(2'b00, {116'd0, P3, 12'hABC}, 140, T0, 6, 20, 1'b1, 1, 0, 2'b00, {128'd0, P3});

        rst      = 1'b1;
        tx_data  = '0;
        spi.sclk = 1'b0;
        spi.cs_n = 1'b1;
        spi.mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        chk("reset rx_valid", 256'(rx_valid), 256'd0);
        chk("reset frame_err", 256'(frame_err), 256'd0);
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset miso", 256'(spi.miso), 256'd0);
        chk("reset rx_mode", 256'(rx_mode), 256'd0);
        chk("reset rx_data", rx_data, 256'd0);

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], -1, k);
        end

        // cs_n rises on the very same pin instant as the final sclk fall.
        run_frame(mk(2'b10, P1, 256, T0, 0, 20, 1'b1, 1, 0, 2'b10, P1), -1, 8);

        // Reset at payload bit 50 with cs_n held low: frame discarded, outputs cleared.
        run_frame(mk(2'b00, {128'd0, P0}, 128, T1, 6, 20, 1'b0, 0, 0, 2'b00, 256'd0), 52, 9);

        // A fresh frame after cs_n has been high is accepted again.
        run_frame(mk(2'b00, {128'd0, P0}, 128, T1, 6, 20, 1'b1, 1, 0, 2'b00, {128'd0, P0}), -1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_sub_aes.md
Name: spi_sub_aes

Overview:
- SPI subordinate endpoint for the AES link.
- Receives the main's frame: 2-bit key-size header, then a 128/192/256-bit payload, MSB first.
- Shifts a 128-bit result back on miso during the first 128 bit periods of the frame.
- Runs on the system clock: sclk, cs_n and mosi are oversampled, not used as clocks. Sits between the SPI pins and the AES core's key/result registers.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk, cs_n and mosi.
- RESULT_W, 128: width of the result shifted out on miso.
- MAX_PAYLOAD, 256: width of the payload register.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from main; idles low.
- cs_n  input  1  active-low chip select.
- mosi  input  1  serial data from main.
- miso  output  1  serial data to main.
- tx_data  input  RESULT_W  result to return; latched on the cs_n falling edge.
- rx_mode  output  2  header of the last accepted frame.
- rx_data  output  MAX_PAYLOAD  payload, right-aligned; unused MSBs are 0.
- rx_valid  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  one-clk pulse on an aborted or invalid frame.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset: all outputs 0; FSM to WAIT_IDLE.
- Reset asserted mid-frame: discard the frame; accept nothing until cs_n has been sampled high.
- Sync path: SYNC_STAGES flops on each input, then one edge-detect register.
  - Pin-to-event latency is SYNC_STAGES+1 clk.
  - Edges are detected on synchronized sclk only while synchronized cs_n is low.
- Protocol timing: the main changes mosi on sclk rise and samples miso on sclk fall. Therefore:
  - mosi is sampled on the detected sclk fall.
  - miso is updated on the detected sclk rise.
- miso bit index is fall_cnt, the number of falls so far in the frame.
  - On each rise with fall_cnt < RESULT_W: miso <= tx_shadow[RESULT_W-1-fall_cnt].
  - Otherwise miso <= 0.
  - At the cs_n fall: miso <= tx_shadow MSB, so bit 0 is valid before the first fall.
- FSM states:
  - WAIT_IDLE: go to IDLE when cs_n is sampled high.
  - IDLE: on the cs_n fall, latch tx_data into tx_shadow, clear counters and set busy; go to HDR.
  - HDR: shift 2 mosi bits into rx_mode_next. After the 2nd fall, decode the payload length:
    - 00 gives 128; 01 gives 192; 10 gives 256; go to PAYLOAD.
    - 11: pulse frame_err, go to DRAIN.
  - PAYLOAD: shift mosi into payload_sr (left shift, LSB in). When len bits are taken:
    - rx_data <= payload_sr zero-extended; rx_mode <= header.
    - Pulse rx_valid in the clk after the last fall; go to DRAIN.
  - DRAIN: ignore further edges; on the cs_n rise, clear busy and go to IDLE.
- cs_n rise in HDR or PAYLOAD (short frame): pulse frame_err, keep rx_data/rx_mode unchanged, clear busy, go to IDLE.
- rx_data and rx_mode hold their values until the next valid frame.
- tx_data changes during a frame have no effect.
- Counters are 9-bit, saturating at 511; no wrap.
- Frames longer than the decoded length: extra bits ignored; no error.
- A cs_n rise in the same clk as the final fall: the fall is processed first, so the frame completes with rx_valid and no frame_err.
- miso is 0 whenever cs_n is high; no tristate.

Decomposition:
- Shared package spi_aes_pkg:
  - mode codes MODE_128=2'b00, MODE_192=2'b01, MODE_256=2'b10.
  - payload length constants 128/192/256 and HDR_BITS=2.
  - FSM state enum.
- One sub-module spi_sync_edge: synchronizer chain plus rise/fall detect, instantiated for sclk and cs_n; mosi uses its sync output only.

Test Plan:
- Mode 00, payload 128'h000102030405060708090A0B0C0D0E0F, tx_data=128'hDEADBEEF...CAFE:
  - rx_valid pulses once; rx_mode=00; rx_data[127:0] matches, upper bits 0.
  - Main captures 128'hDEADBEEF...CAFE.
- Mode 10, 256-bit payload of alternating A5/5A bytes: rx_valid once; rx_data matches all 256 bits; miso is 0 after bit 127.
- Mode 01, 192 bits, then a mode-00 frame back-to-back with one clk-period cs_n high gap:
  - Two rx_valid pulses.
  - The second frame's rx_data upper 128 bits are 0.
- Mode 11 header: frame_err pulses after the 2nd fall; no rx_valid; rx_data keeps the previous value; miso still shifts tx_data.
- cs_n raised after 100 payload bits of a mode-00 frame: frame_err pulses; rx_data unchanged; the next full frame is accepted normally.
- rst pulsed mid-frame at bit 50 with cs_n held low: no rx_valid until cs_n goes high and a fresh frame completes.
